// File: rtl/msi_requester_fsm_if.sv
// msi_requester_fsm_if
//   Groups the CPU-side request/response signals and the snooping-bus
//   signals of the MSI requester controller.
//   master : the requester controller (drives cpu_ready/erro, bus_*, novo_estado,
//            estado_we, busy; samples CPU request, bus_gnt, bus_done, estado_linha)
//   slave  : the environment (CPU, bus arbiter, cache state array)
//
// Handshakes:
//   CPU   : cpu_valid is only looked at while the controller is idle (busy = 0);
//           the request completes with a one-cycle cpu_ready pulse, with erro
//           qualifying it as a timeout abort.
//   Bus   : bus_req stays high from arbitration until bus_done; bus_gnt is only
//           acted on while arbitrating; bus_valid/bus_op/writeback are stable
//           until bus_done, which is ignored when no transaction is on the bus.
interface msi_requester_fsm_if;
  logic       cpu_valid;
  logic       cpu_write;
  logic       cpu_hit;
  logic [1:0] estado_linha;
  logic       cpu_ready;
  logic       erro;
  logic       bus_req;
  logic       bus_gnt;
  logic       bus_valid;
  logic [1:0] bus_op;
  logic       writeback;
  logic       bus_done;
  logic [1:0] novo_estado;
  logic       estado_we;
  logic       busy;

  modport master (
    input  cpu_valid, cpu_write, cpu_hit, estado_linha, bus_gnt, bus_done,
    output cpu_ready, erro, bus_req, bus_valid, bus_op, writeback,
           novo_estado, estado_we, busy
  );

  modport slave (
    output cpu_valid, cpu_write, cpu_hit, estado_linha, bus_gnt, bus_done,
    input  cpu_ready, erro, bus_req, bus_valid, bus_op, writeback,
           novo_estado, estado_we, busy
  );
endinterface

// File: rtl/msi_requester_fsm.sv
// msi_requester_fsm
//   Processor-side MSI coherence controller for one cache. Converts CPU
//   read/write requests into bus read-miss / write-miss / invalidate
//   transactions, writing back a dirty victim first when needed, then commits
//   the new line state (00 I, 01 S, 10 M) to the cache state array.
// Ports:
//   clock     : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   bus       : msi_requester_fsm_if.master (CPU request/response + bus)
//   state_dbg : current FSM state (IDLE 0, WB_ARB 1, WB_BUS 2, ARB 3, BUS 4, DONE 5)
// Parameters:
//   MAX_WAIT  : cycles allowed waiting for bus_gnt before abort; 0 = no timeout
//   WAIT_W    : wait counter width, 2**WAIT_W > MAX_WAIT
module msi_requester_fsm #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  msi_requester_fsm_if.master bus,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WB_ARB = 3'd1,
    S_WB_BUS = 3'd2,
    S_ARB    = 3'd3,
    S_BUS    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] LS_I = 2'b00;
  localparam logic [1:0] LS_S = 2'b01;
  localparam logic [1:0] LS_M = 2'b10;

  localparam logic [1:0] OP_WB  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_INV = 2'b11;

  // The abort fires on the last permitted wait cycle, so the counter only
  // ever has to hold MAX_WAIT-1.
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
  localparam bit                TIMEOUT_EN = (MAX_WAIT != 0);

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        target_q, target_d;
  logic              need_bus_q, need_bus_d;
  logic              erro_q, erro_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic line_hit;
  logic timeout;

  // A tag match on an Invalid line is a miss.
  assign line_hit = bus.cpu_hit && (bus.estado_linha != LS_I);
  // Grant wins over a timeout reached in the same cycle.
  assign timeout  = TIMEOUT_EN && (wait_q == WAIT_LAST) && !bus.bus_gnt;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_WB;
      target_q   <= LS_I;
      need_bus_q <= 1'b0;
      erro_q     <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      target_q   <= target_d;
      need_bus_q <= need_bus_d;
      erro_q     <= erro_d;
      wait_q     <= wait_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    target_d   = target_q;
    need_bus_d = need_bus_q;
    erro_d     = erro_q;
    wait_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_valid) begin
          erro_d = 1'b0;
          if (line_hit && !bus.cpu_write) begin
            need_bus_d = 1'b0;
            state_d    = S_DONE;
          end else if (line_hit && bus.estado_linha == LS_M) begin
            need_bus_d = 1'b0;
            state_d    = S_DONE;
          end else if (line_hit) begin
            // Write to a Shared line: upgrade via invalidate.
            need_bus_d = 1'b1;
            op_d       = OP_INV;
            target_d   = LS_M;
            state_d    = S_ARB;
          end else begin
            need_bus_d = 1'b1;
            op_d       = bus.cpu_write ? OP_WR : OP_RD;
            target_d   = bus.cpu_write ? LS_M : LS_S;
            // Only a tag-mismatched Modified line is a dirty victim.
            state_d    = (!bus.cpu_hit && bus.estado_linha == LS_M) ? S_WB_ARB : S_ARB;
          end
        end
      end
      S_WB_ARB: begin
        if (bus.bus_gnt) begin
          state_d = S_WB_BUS;
        end else if (timeout) begin
          erro_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB_BUS: begin
        if (bus.bus_done) state_d = S_ARB;
      end
      S_ARB: begin
        // Snoop side invalidated our Shared copy while we waited: the
        // upgrade must now fetch the line as a full write miss.
        if (op_q == OP_INV && bus.estado_linha == LS_I) op_d = OP_WR;
        if (bus.bus_gnt) begin
          state_d = S_BUS;
        end else if (timeout) begin
          erro_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_BUS: begin
        if (bus.bus_done) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode
  always_comb begin
    bus.cpu_ready   = 1'b0;
    bus.erro        = 1'b0;
    bus.bus_req     = 1'b0;
    bus.bus_valid   = 1'b0;
    bus.bus_op      = OP_WB;
    bus.writeback   = 1'b0;
    bus.novo_estado = LS_I;
    bus.estado_we   = 1'b0;
    bus.busy        = (state_q != S_IDLE);
    state_dbg       = state_q;
    case (state_q)
      S_WB_ARB: bus.bus_req = 1'b1;
      S_WB_BUS: begin
        bus.bus_req   = 1'b1;
        bus.bus_valid = 1'b1;
        bus.bus_op    = OP_WB;
        bus.writeback = 1'b1;
      end
      S_ARB: bus.bus_req = 1'b1;
      S_BUS: begin
        bus.bus_req   = 1'b1;
        bus.bus_valid = 1'b1;
        bus.bus_op    = op_q;
      end
      S_DONE: begin
        bus.cpu_ready = 1'b1;
        bus.erro      = erro_q;
        if (need_bus_q && !erro_q) begin
          bus.estado_we   = 1'b1;
          bus.novo_estado = target_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/msi_requester_fsm.md
Name: msi_requester_fsm

Overview:
- Processor-side (requester) controller for one cache's MSI coherence traffic; the counterpart of the snoop-side listener FSM.
- Turns CPU read/write requests into snooping-bus transactions: read miss, write miss, invalidate. Writes back a dirty victim first when required.
- Arbitrates for the shared bus, waits for completion, then commits the new line state to the cache state array.
- Line-state encoding: 00 Invalid, 01 Shared, 10 Modified.
- Bus-op encoding: 00 none/writeback, 01 read miss, 10 write miss, 11 invalidate.

Parameters:
MAX_WAIT, 255, cycles allowed waiting for bus_gnt before the request is aborted with erro; 0 disables the timeout.
WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
clock  in  1  system clock; rising edge
reset_n  in  1  asynchronous active-low reset
cpu_valid  in  1  CPU request present
cpu_write  in  1  1 = write, 0 = read
cpu_hit  in  1  tag match for the addressed line
estado_linha  in  2  current MSI state of the addressed line (live; snoop side may change it)
cpu_ready  out  1  one-cycle completion pulse
erro  out  1  with cpu_ready: request aborted by timeout
bus_req  out  1  bus arbitration request
bus_gnt  in  1  bus grant
bus_valid  out  1  bus_op/writeback are valid on the bus
bus_op  out  2  bus transaction code
writeback  out  1  current bus transaction is a victim writeback
bus_done  in  1  bus transaction complete
novo_estado  out  2  state to write into the cache state array
estado_we  out  1  write enable for novo_estado, one cycle
busy  out  1  controller not in IDLE

Behaviour:
- Reset (async, any state): FSM goes to IDLE; wait counter 0; all outputs 0; latched request cleared.
- States: IDLE, WB_ARB, WB_BUS, ARB, BUS, DONE. Registered Moore outputs.
- IDLE: cpu_valid is sampled here only. A hit with estado_linha = 00 counts as a miss. Request fields (write, op, target) latch on acceptance. Decode:
  - read hit (01/10) -> DONE; no bus op, estado_we = 0 (latency 1: cpu_ready the next cycle).
  - write hit in 10 -> DONE; no bus op, no state write.
  - write hit in 01 -> ARB with op = 11, target = 10.
  - read miss -> op = 01, target = 01.
  - write miss -> op = 10, target = 10.
  - For either miss: go to WB_ARB if !cpu_hit and estado_linha = 10 (dirty victim); otherwise go to ARB.
- WB_ARB: bus_req = 1. On bus_gnt -> WB_BUS.
- WB_BUS: bus_req = 1, bus_valid = 1, bus_op = 00, writeback = 1. Hold until bus_done, then -> ARB. Bus ownership is kept; the next grant is still required.
- ARB: bus_req = 1. On bus_gnt -> BUS. If the pending op is 11 and estado_linha reads 00 (snoop invalidated the line), op becomes 10. The target stays 10.
- BUS: bus_req = 1, bus_valid = 1, bus_op = op. Outputs are stable until bus_done, then -> DONE. bus_done outside WB_BUS/BUS is ignored.
- DONE (one cycle): cpu_ready = 1. If a bus op completed: estado_we = 1, novo_estado = target. Then -> IDLE. A new request can be accepted the following cycle; cpu_valid held high does not re-trigger inside DONE.
- Timeout: the counter increments each cycle in WB_ARB/ARB without bus_gnt and clears on grant or state exit. When it reaches MAX_WAIT (and MAX_WAIT ≠ 0): -> DONE with erro = 1, estado_we = 0, bus_req dropped.
- bus_gnt arriving on the same cycle the timeout is reached: the grant wins.
- busy = 1 in every state except IDLE.

Test Plan:
- Reset mid-BUS (bus_valid = 1, op = 10), reset_n low -> all outputs 0 immediately; after release, busy = 0 and no spurious estado_we.
- Read hit, estado_linha = 01 -> cpu_ready on the next cycle, bus_req never asserted, estado_we = 0.
- Write hit in 01, bus_gnt after 3 cycles, bus_done 2 cycles later -> bus_op = 11 with bus_valid; then DONE with estado_we = 1, novo_estado = 10.
- Read miss, victim estado_linha = 10, cpu_hit = 0 -> writeback transaction (bus_op = 00, writeback = 1) first, then bus_op = 01 after the second grant; novo_estado = 01.
- Write hit in 01; in ARB, estado_linha is forced to 00 before the grant -> issued bus_op = 10; final novo_estado = 10.
- MAX_WAIT = 4, bus_gnt held low -> cpu_ready and erro = 1 after 4 wait cycles, estado_we = 0. Repeat with bus_gnt arriving on cycle 4 -> no erro, transaction proceeds.
